irq_front_ctrl: RTL and testbench
=================================

// Module: irq_front_ctrl
// PURPOSE
//  Interrupt front-end between the board interrupt buttons and the MIPS_CPU interrupt inputs.
//  - Synchronises and debounces the raw button lines.
//  - Latches rising edges as pending requests.
//  - Presents one prioritised request to the CPU with a req/ack handshake.
//  - Tracks in-service (nested) levels until the CPU signals ERET.
//  - Drives the inter_running LEDs from the in-service state.
// PARAMETERS
//  NUM_IRQ     3   number of interrupt lines; line NUM_IRQ-1 is highest priority
//  DEB_CYCLES  4   consecutive stable samples required to accept a level change (min 1)
//  CNT_W       8   width of the per-line debounce counter; must hold DEB_CYCLES
// PORTS
//  clk          in   1        CPU clock (divided clk_N domain); all logic on posedge
//  clr          in   1        asynchronous reset, active-low
//  btn          in   NUM_IRQ  raw asynchronous, bouncy interrupt buttons (inter1..3)
//  irq_ack      in   1        CPU pulse: request taken (EPC saved), one cycle
//  irq_eret     in   1        CPU pulse: ERET executed, one cycle
//  irq_req      out  1        level: a request is presented to the CPU
//  irq_id       out  2        index of the presented line; valid while irq_req=1
//  irq_running  out  NUM_IRQ  in-service bits, drive inter_running1..3 LEDs
// BEHAVIOUR
//  Reset (clr=0, async): sync/debounce regs=0, pending=0, in_svc=0, FSM=IDLE,
//   irq_req=0, irq_id=0, irq_running=0.
//  Input path per line:
//   - 2-flop synchroniser.
//   - Counter increments while the synced value differs from the accepted level, clears otherwise.
//   - On reaching DEB_CYCLES: accepted level flips, counter clears.
//   - A 0->1 accepted-level flip sets pending[i] next edge.
//  Latency: btn held high from edge 0 -> pending[i]=1 after edge DEB_CYCLES+3
//   -> irq_req=1 after edge DEB_CYCLES+4.
//  Eligible lines: pending[i]=1 AND i > highest set in_svc bit (any i if in_svc=0).
//  FSM:
//   - IDLE: eligible set nonempty -> REQ. Latch irq_id = highest eligible; irq_req=1 next cycle.
//   - REQ: irq_id frozen, even if a higher line becomes pending.
//     - irq_ack=1: pending[id] clears, in_svc[id] sets, irq_req drops next cycle, -> IDLE.
//  irq_eret: clears the highest set in_svc bit; ignored if in_svc=0.
//  Simultaneous events:
//   - new edge on line i in the same cycle as ack of i -> pending[i] stays 1 (set wins).
//   - ack + eret same cycle -> both applied; eret clears highest bit before ack sets.
//  Edge on an already-pending line -> merged, no second request.
//  irq_ack outside REQ -> ignored.
//  Reset mid-handshake -> all state cleared, request lost.
//  irq_running = in_svc registered copy (same cycle as in_svc update).
// CONFIGURATION
//  IRQ_MASK_EN:
//   - Defined: adds input irq_mask[NUM_IRQ-1:0]; eligible additionally requires mask[i]=1.
//     Masked lines still latch pending and present once unmasked.
//     Mask does not affect a request already in REQ.
//   - Undefined: port absent, all lines enabled.
// STRUCTURE
//  Package irq_pkg:
//   - NUM_IRQ default
//   - state enum {IDLE, REQ}
//   - function prio_top(vec) returning index of highest set bit
//   - function above_mask(level) returning eligible mask
//  Sub-module irq_debounce: one per line (synchroniser + counter + edge pulse),
//   generated NUM_IRQ times. All pending/in_svc/FSM logic stays in irq_front_ctrl.
// TESTING
//  1. btn[0] rises, held; DEB_CYCLES=4 -> irq_req=1, irq_id=0 exactly 8 edges later;
//     ack -> irq_running=3'b001, irq_req=0 next cycle.
//  2. btn[0] toggles every 2 cycles for 20 cycles, then stays 0 -> pending never set, irq_req stays 0.
//  3. Line 0 in service, btn[2] pressed -> irq_req, irq_id=2 (nesting); ack -> irq_running=3'b101;
//     eret -> 3'b001; eret -> 3'b000.
//  4. Line 2 in service, btn[1] pressed -> no request; after eret -> irq_req=1, irq_id=1.
//  5. In REQ with id=0, btn[2] pressed -> irq_id stays 0 until ack; then IDLE -> REQ with irq_id=2.
//  6. clr pulled low while irq_req=1, in_svc=3'b010 -> all outputs 0 immediately (async), IDLE after release.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types and priority helpers for the interrupt front-end.
// Helpers work on a 4-bit vector: irq_id is 2 bits wide, so at most 4 lines exist.
package irq_pkg;

  localparam int NUM_IRQ_DEF = 3;
  localparam int MAX_IRQ     = 4;

  typedef logic [MAX_IRQ-1:0] irq_vec_t;
  typedef logic [1:0]         irq_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  function automatic irq_idx_t prio_top(input irq_vec_t vec);
    irq_idx_t idx;
    idx = '0;
    for (int i = 0; i < MAX_IRQ; i++) begin
      if (vec[i]) idx = irq_idx_t'(i);
    end
    return idx;
  endfunction

  // Lines allowed to preempt the given in-service set: strictly above its top bit.
  function automatic irq_vec_t above_mask(input irq_vec_t level);
    irq_vec_t m;
    irq_idx_t top;
    m = '1;
    if (level != '0) begin
      top = prio_top(level);
      for (int i = 0; i < MAX_IRQ; i++) begin
        m[i] = (i > int'(top));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/irq_debounce.sv
// One button line: 2-flop synchroniser, stability counter, registered rising-edge pulse.
module irq_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_raw,
  output logic rise
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             level_dly_q, level_dly_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    level_d     = level_q;
    cnt_d       = '0;
    level_dly_d = level_q;
    rise_d      = level_q & ~level_dly_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      rise_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      rise_q      <= rise_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/irq_front_ctrl.sv
// Interrupt front-end: debounced edges -> pending -> prioritised req/ack -> nested in-service.
// Optional IRQ_MASK_EN adds an irq_mask input gating which pending lines may be presented.
module irq_front_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ    = NUM_IRQ_DEF,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] btn,
`ifdef IRQ_MASK_EN
  input  logic [NUM_IRQ-1:0] irq_mask,
`endif
  input  logic               irq_ack,
  input  logic               irq_eret,
  output logic               irq_req,
  output logic [1:0]         irq_id,
  output logic [NUM_IRQ-1:0] irq_running
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_svc_q, in_svc_d;
  irq_idx_t           irq_id_q, irq_id_d;
  state_t             state_q, state_d;

  irq_vec_t pend_ext, svc_ext, mask_ext, eligible;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IRQ; gi++) begin : g_deb
      irq_debounce #(
        .DEB_CYCLES(DEB_CYCLES),
        .CNT_W     (CNT_W)
      ) u_deb (
        .clk    (clk),
        .clr    (clr),
        .btn_raw(btn[gi]),
        .rise   (rise[gi])
      );
    end
  endgenerate

  always_comb begin
    pend_ext = '0;
    svc_ext  = '0;
    mask_ext = '0;
    pend_ext[NUM_IRQ-1:0] = pending_q;
    svc_ext[NUM_IRQ-1:0]  = in_svc_q;
`ifdef IRQ_MASK_EN
    mask_ext[NUM_IRQ-1:0] = irq_mask;
`else
    mask_ext[NUM_IRQ-1:0] = '1;
`endif
    eligible = pend_ext & above_mask(svc_ext) & mask_ext;

    state_d   = state_q;
    irq_id_d  = irq_id_q;
    pending_d = pending_q;
    in_svc_d  = in_svc_q;

    case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          state_d  = REQ;
          irq_id_d = prio_top(eligible);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d             = IDLE;
          pending_d[irq_id_q] = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // ERET retires the current level before a same-cycle ack adds the new one.
    if (irq_eret && (svc_ext != '0)) begin
      in_svc_d[prio_top(svc_ext)] = 1'b0;
    end
    if ((state_q == REQ) && irq_ack) begin
      in_svc_d[irq_id_q] = 1'b1;
    end

    // A fresh edge outranks the ack clear of the same line.
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      irq_id_q  <= '0;
      pending_q <= '0;
      in_svc_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      in_svc_q  <= in_svc_d;
    end
  end

  assign irq_req     = (state_q == REQ);
  assign irq_id      = irq_id_q;
  assign irq_running = in_svc_q;

endmodule

// File: tb/tb_irq_front_ctrl.sv
// Bench for irq_front_ctrl: latency table, nesting/corner sequences, randomised run vs model.
module tb_irq_front_ctrl;

  localparam int N   = 3;
  localparam int DEB = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [N-1:0] btn = '0;
  logic         irq_ack = 1'b0;
  logic         irq_eret = 1'b0;
  logic         irq_req;
  logic [1:0]   irq_id;
  logic [N-1:0] irq_running;
`ifdef IRQ_MASK_EN
  logic [N-1:0] irq_mask = '1;
`endif

  irq_front_ctrl #(.NUM_IRQ(N), .DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .btn        (btn),
`ifdef IRQ_MASK_EN
    .irq_mask   (irq_mask),
`endif
    .irq_ack    (irq_ack),
    .irq_eret   (irq_eret),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .irq_running(irq_running)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget, input string name);
    for (int i = 0; i < budget && !irq_req; i++) step();
    check(name, irq_req, 1);
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    $display("ack: req=%0b running=%b", irq_req, irq_running);
  endtask

  task automatic do_eret();
    irq_eret = 1'b1;
    step();
    irq_eret = 1'b0;
    $display("eret: running=%b", irq_running);
  endtask

  // ---------------- behavioural reference model ----------------
  logic         m_req;
  logic [1:0]   m_id;
  logic [N-1:0] m_pend, m_svc;
  logic [N-1:0] m_d1, m_d2, m_lvl;
  int           m_run [N];
  int           m_cd  [N];

  function automatic int top_of(input logic [N-1:0] v);
    int t = -1;
    for (int i = 0; i < N; i++) if (v[i]) t = i;
    return t;
  endfunction

  always @(posedge clk or negedge clr) begin : model
    logic [N-1:0] el, np, ns, d1, d2, lv;
    logic         nreq;
    logic [1:0]   nid;
    int           hi, s;
    int           run [N];
    int           cd  [N];
    if (!clr) begin
      m_req <= 1'b0; m_id <= '0; m_pend <= '0; m_svc <= '0;
      m_d1 <= '0; m_d2 <= '0; m_lvl <= '0;
      for (int i = 0; i < N; i++) begin m_run[i] <= 0; m_cd[i] <= 0; end
    end else begin
      hi = top_of(m_svc);
      el = '0;
      for (int i = 0; i < N; i++) if (m_pend[i] && i > hi) el[i] = 1'b1;
      np = m_pend; ns = m_svc; nreq = m_req; nid = m_id;
      if (!m_req) begin
        if (el != '0) begin nreq = 1'b1; nid = 2'(top_of(el)); end
      end else if (irq_ack) begin
        nreq = 1'b0; np[m_id] = 1'b0;
      end
      if (irq_eret && hi >= 0) ns[hi] = 1'b0;
      if (m_req && irq_ack) ns[m_id] = 1'b1;
      d1 = m_d1; d2 = m_d2; lv = m_lvl;
      for (int i = 0; i < N; i++) begin
        run[i] = m_run[i]; cd[i] = m_cd[i];
        if (cd[i] == 1) np[i] = 1'b1;
        if (cd[i] > 0) cd[i]--;
        s = int'(d2[i]);        // button value sampled two edges ago
        d2[i] = d1[i];
        d1[i] = btn[i];
        if (s != int'(lv[i])) begin
          run[i]++;
          if (run[i] == DEB) begin
            lv[i] = ~lv[i];
            run[i] = 0;
            if (lv[i]) cd[i] = 2;
          end
        end else begin
          run[i] = 0;
        end
      end
      m_req <= nreq; m_id <= nid; m_pend <= np; m_svc <= ns;
      m_d1 <= d1; m_d2 <= d2; m_lvl <= lv;
      for (int i = 0; i < N; i++) begin m_run[i] <= run[i]; m_cd[i] <= cd[i]; end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] btn;
    logic       ack;
    logic       eret;
    logic       req;
    logic [1:0] id;
    logic [2:0] run;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit seen;
    bit bad;

    for (int k = 0; k < 8; k++) tbl[k] = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};
    tbl[8]  = '{3'b001, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000};
    tbl[9]  = '{3'b001, 1'b1, 1'b0, 1'b0, 2'd0, 3'b001};
    tbl[10] = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 3'b001};
    tbl[11] = '{3'b001, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000};
    tbl[12] = '{3'b001, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000};

    // Reset state
    #12;
    check("rst_req", irq_req, 0);
    check("rst_id", irq_id, 0);
    check("rst_running", irq_running, 0);
    step();
    clr = 1'b1;

    // 1: latency and first handshake
    for (int k = 0; k < 13; k++) begin
      btn = tbl[k].btn; irq_ack = tbl[k].ack; irq_eret = tbl[k].eret;
      step();
      $display("vec %0d: req=%0b id=%0d running=%b", k, irq_req, irq_id, irq_running);
      check($sformatf("tbl%0d_req", k), irq_req, tbl[k].req);
      if (tbl[k].req) check($sformatf("tbl%0d_id", k), irq_id, tbl[k].id);
      check($sformatf("tbl%0d_running", k), irq_running, tbl[k].run);
    end
    irq_ack = 0; irq_eret = 0; btn = '0;
    repeat (10) step();

    // 2: bouncing shorter than the debounce window
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      btn[0] = ((c / 2) % 2) == 0;
      step();
      seen |= irq_req;
    end
    btn = '0;
    repeat (12) begin step(); seen |= irq_req; end
    check("sc2_no_req", seen, 0);

    // 3: nesting a higher line over line 0
    btn = 3'b001;
    wait_req(14, "sc3_req0");
    check("sc3_id0", irq_id, 0);
    do_ack();
    check("sc3_run001", irq_running, 1);
    btn = '0; repeat (10) step();
    btn = 3'b100;
    wait_req(14, "sc3_req2");
    check("sc3_id2", irq_id, 2);
    do_ack();
    check("sc3_run101", irq_running, 5);
    btn = '0; repeat (10) step();
    do_eret();
    check("sc3_eret1", irq_running, 1);
    do_eret();
    check("sc3_eret2", irq_running, 0);
    check("sc3_no_req", irq_req, 0);

    // 4: lower line blocked until ERET
    btn = 3'b100;
    wait_req(14, "sc4_req2");
    check("sc4_id2", irq_id, 2);
    do_ack();
    btn = '0; repeat (10) step();
    check("sc4_run100", irq_running, 4);
    btn = 3'b010;
    seen = 0;
    repeat (14) begin step(); seen |= irq_req; end
    check("sc4_blocked", seen, 0);
    do_eret();
    check("sc4_eret_run", irq_running, 0);
    wait_req(3, "sc4_req1_after_eret");
    check("sc4_id1", irq_id, 1);
    do_ack();
    check("sc4_run010", irq_running, 2);
    btn = '0; repeat (10) step();
    do_eret();
    check("sc4_final_run", irq_running, 0);

    // 5: id frozen while a higher line arrives
    btn = 3'b001;
    wait_req(14, "sc5_req0");
    check("sc5_id0", irq_id, 0);
    btn = 3'b101;
    bad = 0;
    repeat (14) begin step(); if (!irq_req || irq_id != 2'd0) bad = 1; end
    check("sc5_frozen", bad, 0);
    do_ack();
    check("sc5_run001", irq_running, 1);
    wait_req(3, "sc5_req2");
    check("sc5_id2", irq_id, 2);
    do_ack();
    check("sc5_run101", irq_running, 5);
    btn = '0; repeat (10) step();
    do_eret(); do_eret();
    check("sc5_final_run", irq_running, 0);

    // 6: async reset during a handshake
    btn = 3'b010;
    wait_req(14, "sc6_req1");
    do_ack();
    btn = '0; repeat (10) step();
    btn = 3'b100;
    wait_req(14, "sc6_req2");
    check("sc6_pre_run", irq_running, 2);
    #3 clr = 1'b0;
    #1;
    check("sc6_rst_req", irq_req, 0);
    check("sc6_rst_id", irq_id, 0);
    check("sc6_rst_running", irq_running, 0);
    btn = '0;
    step();
    clr = 1'b1;
    seen = 0;
    repeat (10) begin step(); seen |= irq_req; end
    check("sc6_req_lost", seen, 0);
    btn = 3'b001;
    wait_req(14, "sc6_idle_req");
    check("sc6_idle_id", irq_id, 0);
    do_ack();
    btn = '0; repeat (10) step();
    do_eret();

    // Randomised run against the reference model
    clr = 1'b0;
    step();
    clr = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) btn[i] = ~btn[i];
      irq_ack  = irq_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
      irq_eret = ($urandom_range(0, 19) == 0);
      step();
      check("rnd_req", irq_req, m_req);
      if (m_req) check("rnd_id", irq_id, m_id);
      check("rnd_running", irq_running, m_svc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
